// File: rtl/ray_scan_sequencer.sv
// Per-column ray sequencer: walks every wall through the external intersection unit and
// emits the nearest hit per column. Optional far-clip filter enabled by RAY_SCAN_FAR_CLIP_EN.
module ray_scan_sequencer #(
    parameter int          NUM_COLS = 160,
    parameter int          WALL_AW  = 6,
    parameter logic [15:0] FAR_CLIP = 16'h4000,
    localparam int         CW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [15:0]        player_x_i,
    input  logic [15:0]        player_y_i,
    input  logic [WALL_AW:0]   wall_count_i,
    output logic [CW-1:0]      ray_addr_o,
    input  logic [15:0]        ray_dx_i,
    input  logic [15:0]        ray_dy_i,
    output logic [WALL_AW-1:0] wall_addr_o,
    input  logic [15:0]        wall_x3_i,
    input  logic [15:0]        wall_y3_i,
    input  logic [15:0]        wall_x4_i,
    input  logic [15:0]        wall_y4_i,
    output logic [15:0]        rc_x1_o,
    output logic [15:0]        rc_y1_o,
    output logic [15:0]        rc_x2_o,
    output logic [15:0]        rc_y2_o,
    output logic [15:0]        rc_x3_o,
    output logic [15:0]        rc_y3_o,
    output logic [15:0]        rc_x4_o,
    output logic [15:0]        rc_y4_o,
    input  logic               rc_hit_i,
    input  logic [15:0]        rc_dist_i,
    input  logic [15:0]        rc_uv_i,
    output logic               col_valid_o,
    input  logic               col_ready_i,
    output logic [CW-1:0]      col_index_o,
    output logic               col_hit_o,
    output logic [15:0]        col_dist_o,
    output logic [15:0]        col_uv_o,
    output logic [WALL_AW-1:0] col_wall_o,
    output logic               busy_o,
    output logic               frame_done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAY_RD  = 3'd1,
        S_RAY_LD  = 3'd2,
        S_WALL_RD = 3'd3,
        S_WALL_LD = 3'd4,
        S_CMP     = 3'd5,
        S_EMIT    = 3'd6
    } state_e;

    localparam logic [WALL_AW:0] MAX_WALLS = {1'b1, {WALL_AW{1'b0}}};
    localparam logic [CW-1:0]    LAST_COL  = CW'(NUM_COLS - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [WALL_AW-1:0]   w_q, w_d;
    logic [WALL_AW:0]     cnt_q, cnt_d;
    logic [15:0]          px_q, px_d, py_q, py_d;
    logic [15:0]          rc_x1_q, rc_x1_d, rc_y1_q, rc_y1_d, rc_x2_q, rc_x2_d, rc_y2_q, rc_y2_d;
    logic [15:0]          rc_x3_q, rc_x3_d, rc_y3_q, rc_y3_d, rc_x4_q, rc_x4_d, rc_y4_q, rc_y4_d;
    logic                 best_hit_q, best_hit_d;
    logic [15:0]          best_dist_q, best_dist_d, best_uv_q, best_uv_d;
    logic [WALL_AW-1:0]   best_wall_q, best_wall_d;
    logic                 col_valid_q, col_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 cand_s;
    logic                 last_wall_s;

`ifdef RAY_SCAN_FAR_CLIP_EN
    assign cand_s = rc_hit_i && (rc_dist_i < FAR_CLIP);
`else
    logic far_clip_unused_s;
    assign far_clip_unused_s = ^FAR_CLIP;
    assign cand_s = rc_hit_i;
`endif

    assign last_wall_s = ({1'b0, w_q} == (cnt_q - {{WALL_AW{1'b0}}, 1'b1}));

    // Next-state and datapath update for the scan FSM
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        w_d          = w_q;
        cnt_d        = cnt_q;
        px_d         = px_q;
        py_d         = py_q;
        rc_x1_d      = rc_x1_q;
        rc_y1_d      = rc_y1_q;
        rc_x2_d      = rc_x2_q;
        rc_y2_d      = rc_y2_q;
        rc_x3_d      = rc_x3_q;
        rc_y3_d      = rc_y3_q;
        rc_x4_d      = rc_x4_q;
        rc_y4_d      = rc_y4_q;
        best_hit_d   = best_hit_q;
        best_dist_d  = best_dist_q;
        best_uv_d    = best_uv_q;
        best_wall_d  = best_wall_q;
        busy_d       = busy_q;
        col_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    px_d    = player_x_i;
                    py_d    = player_y_i;
                    cnt_d   = (wall_count_i > MAX_WALLS) ? MAX_WALLS : wall_count_i;
                    col_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = S_RAY_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RAY_RD: state_d = S_RAY_LD;
            S_RAY_LD: begin
                rc_x1_d     = px_q;
                rc_y1_d     = py_q;
                rc_x2_d     = px_q + ray_dx_i;
                rc_y2_d     = py_q + ray_dy_i;
                best_hit_d  = 1'b0;
                best_dist_d = 16'h0000;
                best_uv_d   = 16'h0000;
                best_wall_d = {WALL_AW{1'b0}};
                w_d         = {WALL_AW{1'b0}};
                if (cnt_q == {(WALL_AW + 1){1'b0}}) begin
                    col_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    state_d     = S_WALL_RD;
                end
            end
            S_WALL_RD: state_d = S_WALL_LD;
            S_WALL_LD: begin
                rc_x3_d = wall_x3_i;
                rc_y3_d = wall_y3_i;
                rc_x4_d = wall_x4_i;
                rc_y4_d = wall_y4_i;
                state_d = S_CMP;
            end
            S_CMP: begin
                // Strict less-than: walls arrive in ascending order, so ties keep the earlier one
                if (cand_s && (!best_hit_q || (rc_dist_i < best_dist_q))) begin
                    best_hit_d  = 1'b1;
                    best_dist_d = rc_dist_i;
                    best_uv_d   = rc_uv_i;
                    best_wall_d = w_q;
                end else begin
                    best_hit_d  = best_hit_q;
                end
                if (last_wall_s) begin
                    col_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    w_d         = w_q + {{(WALL_AW - 1){1'b0}}, 1'b1};
                    state_d     = S_WALL_RD;
                end
            end
            S_EMIT: begin
                if (col_ready_i) begin
                    if (col_q == LAST_COL) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        col_d        = col_q + {{(CW - 1){1'b0}}, 1'b1};
                        state_d      = S_RAY_RD;
                    end
                end else begin
                    col_valid_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= {CW{1'b0}};
            w_q          <= {WALL_AW{1'b0}};
            cnt_q        <= {(WALL_AW + 1){1'b0}};
            px_q         <= 16'h0000;
            py_q         <= 16'h0000;
            rc_x1_q      <= 16'h0000;
            rc_y1_q      <= 16'h0000;
            rc_x2_q      <= 16'h0000;
            rc_y2_q      <= 16'h0000;
            rc_x3_q      <= 16'h0000;
            rc_y3_q      <= 16'h0000;
            rc_x4_q      <= 16'h0000;
            rc_y4_q      <= 16'h0000;
            best_hit_q   <= 1'b0;
            best_dist_q  <= 16'h0000;
            best_uv_q    <= 16'h0000;
            best_wall_q  <= {WALL_AW{1'b0}};
            col_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            w_q          <= w_d;
            cnt_q        <= cnt_d;
            px_q         <= px_d;
            py_q         <= py_d;
            rc_x1_q      <= rc_x1_d;
            rc_y1_q      <= rc_y1_d;
            rc_x2_q      <= rc_x2_d;
            rc_y2_q      <= rc_y2_d;
            rc_x3_q      <= rc_x3_d;
            rc_y3_q      <= rc_y3_d;
            rc_x4_q      <= rc_x4_d;
            rc_y4_q      <= rc_y4_d;
            best_hit_q   <= best_hit_d;
            best_dist_q  <= best_dist_d;
            best_uv_q    <= best_uv_d;
            best_wall_q  <= best_wall_d;
            col_valid_q  <= col_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ray_addr_o   = col_q;
    assign wall_addr_o  = w_q;
    assign rc_x1_o      = rc_x1_q;
    assign rc_y1_o      = rc_y1_q;
    assign rc_x2_o      = rc_x2_q;
    assign rc_y2_o      = rc_y2_q;
    assign rc_x3_o      = rc_x3_q;
    assign rc_y3_o      = rc_y3_q;
    assign rc_x4_o      = rc_x4_q;
    assign rc_y4_o      = rc_y4_q;
    assign col_valid_o  = col_valid_q;
    assign col_index_o  = col_q;
    assign col_hit_o    = best_hit_q;
    assign col_dist_o   = best_dist_q;
    assign col_uv_o     = best_uv_q;
    assign col_wall_o   = best_wall_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ray_scan_sequencer.sv
// Self-checking bench for ray_scan_sequencer: 4 columns, 8-wall RAM, behavioural
// intersection stub keyed on rc_x3 and a per-column nearest-hit reference model.
module tb_ray_scan_sequencer;

    localparam int NC = 4;
    localparam int NW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] player_x, player_y;
    logic [3:0]  wall_count;
    logic [1:0]  ray_addr;
    logic [15:0] ray_dx, ray_dy;
    logic [2:0]  wall_addr;
    logic [15:0] wall_x3, wall_y3, wall_x4, wall_y4;
    logic [15:0] rc_x1, rc_y1, rc_x2, rc_y2, rc_x3, rc_y3, rc_x4, rc_y4;
    logic        rc_hit;
    logic [15:0] rc_dist, rc_uv;
    logic        col_valid, col_ready;
    logic [1:0]  col_index;
    logic        col_hit;
    logic [15:0] col_dist, col_uv;
    logic [2:0]  col_wall;
    logic        busy, frame_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] rdx [NC];
    logic [15:0] rdy [NC];
    logic [15:0] wx3 [NW];
    logic [15:0] wy3 [NW];
    logic [15:0] wx4 [NW];
    logic [15:0] wy4 [NW];
    logic        sh  [NW];
    logic [15:0] sd  [NW];
    logic [15:0] su  [NW];

    logic [15:0] fr_px, fr_py;
    logic        first_hit;
    logic [15:0] first_dist, first_uv;
    logic [2:0]  first_wall;

    ray_scan_sequencer #(.NUM_COLS(NC), .WALL_AW(3), .FAR_CLIP(16'h0400)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .player_x_i(player_x), .player_y_i(player_y), .wall_count_i(wall_count),
        .ray_addr_o(ray_addr), .ray_dx_i(ray_dx), .ray_dy_i(ray_dy),
        .wall_addr_o(wall_addr), .wall_x3_i(wall_x3), .wall_y3_i(wall_y3),
        .wall_x4_i(wall_x4), .wall_y4_i(wall_y4),
        .rc_x1_o(rc_x1), .rc_y1_o(rc_y1), .rc_x2_o(rc_x2), .rc_y2_o(rc_y2),
        .rc_x3_o(rc_x3), .rc_y3_o(rc_y3), .rc_x4_o(rc_x4), .rc_y4_o(rc_y4),
        .rc_hit_i(rc_hit), .rc_dist_i(rc_dist), .rc_uv_i(rc_uv),
        .col_valid_o(col_valid), .col_ready_i(col_ready), .col_index_o(col_index),
        .col_hit_o(col_hit), .col_dist_o(col_dist), .col_uv_o(col_uv), .col_wall_o(col_wall),
        .busy_o(busy), .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read ray table and wall RAM
    always @(posedge clk) begin
        ray_dx  <= rdx[ray_addr];
        ray_dy  <= rdy[ray_addr];
        wall_x3 <= wx3[wall_addr];
        wall_y3 <= wy3[wall_addr];
        wall_x4 <= wx4[wall_addr];
        wall_y4 <= wy4[wall_addr];
    end

    // Intersection stub: wall tag from rc_x3, lightly perturbed by the ray end point
    assign rc_hit  = sh[rc_x3[2:0]] ^ (rc_x2[4] & rc_x3[0]);
    assign rc_dist = sd[rc_x3[2:0]] ^ {12'h000, rc_x2[3:0]};
    assign rc_uv   = su[rc_x3[2:0]] ^ rc_y2;

    function automatic int clamp_walls(input int n);
        return (n > NW) ? NW : n;
    endfunction

    // Nearest valid hit for one column, lowest wall index on equal distance
    task automatic model_col(input int c, input int n, output logic h, output logic [15:0] d,
                             output logic [15:0] u, output logic [2:0] wi);
        logic [15:0] x2, y2, dd;
        logic        hh;
        int          tag;
        x2 = fr_px + rdx[c];
        y2 = fr_py + rdy[c];
        h = 1'b0; d = 16'h0000; u = 16'h0000; wi = 3'd0;
        for (int w = 0; w < clamp_walls(n); w++) begin
            tag = int'(wx3[w][2:0]);
            hh  = sh[tag] ^ (x2[4] & (tag % 2 == 1));
            dd  = sd[tag] ^ {12'h000, x2[3:0]};
`ifdef RAY_SCAN_FAR_CLIP_EN
            if (dd >= 16'h0400) hh = 1'b0;
`endif
            if (hh && (!h || dd < d)) begin
                h = 1'b1; d = dd; u = su[tag] ^ y2; wi = 3'(w);
            end
        end
    endtask

    task automatic fill_walls(input bit rand_hits);
        logic [31:0] r;
        for (int i = 0; i < NW; i++) begin
            r = $urandom;
            wx3[i] = {r[15:3], 3'(i)};
            wy3[i] = r[31:16];
            wx4[i] = 16'($urandom);
            wy4[i] = 16'($urandom);
            sh[i]  = rand_hits ? 1'($urandom_range(0, 1)) : 1'b0;
            sd[i]  = rand_hits ? 16'($urandom) : 16'h0000;
            su[i]  = 16'($urandom);
        end
    endtask

    task automatic setup_directed();
        player_x = 16'h0000;
        player_y = 16'h0000;
        for (int i = 0; i < NC; i++) begin
            rdx[i] = 16'h0000;
            rdy[i] = 16'h0000;
        end
        fill_walls(1'b0);
    endtask

    // Runs one frame; mode 0: ready always 1, 1: random ready/start/player, 2: 10-cycle stall per column
    task automatic run_frame(input int n, input int mode, input string name);
        int col, cyc, last_hs, stall, nn;
        logic pv, pr, r, h;
        logic [15:0] d, u;
        logic [2:0] wi;
        nn = clamp_walls(n);
        @(negedge clk);
        fr_px = player_x;
        fr_py = player_y;
        wall_count = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
        col = 0; cyc = 0; last_hs = 0; stall = 0; pv = 1'b0; pr = 1'b0;
        while (col < NC && cyc < 2000) begin
            if (pv && !pr) begin
                checks++;
                if (col_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s valid_held col %0d: got %b expected 1", name, col, col_valid);
                end
            end
            r = 1'b0;
            if (col_valid === 1'b1) begin
                model_col(col, n, h, d, u, wi);
                checks++;
                if ({col_index, col_hit, col_dist, col_uv, col_wall} !== {2'(col), h, d, u, wi}) begin
                    errors++;
                    $display("FAIL %s result col %0d: got idx=%0d hit=%b dist=%h uv=%h wall=%0d expected idx=%0d hit=%b dist=%h uv=%h wall=%0d",
                             name, col, col_index, col_hit, col_dist, col_uv, col_wall, col, h, d, u, wi);
                end
                checks++;
                if ({rc_x1, rc_y1, rc_x2, rc_y2} !== {fr_px, fr_py, 16'(fr_px + rdx[col]), 16'(fr_py + rdy[col])}) begin
                    errors++;
                    $display("FAIL %s ray_operands col %0d: got %h %h %h %h expected %h %h %h %h", name, col,
                             rc_x1, rc_y1, rc_x2, rc_y2, fr_px, fr_py, 16'(fr_px + rdx[col]), 16'(fr_py + rdy[col]));
                end
                if (nn > 0) begin
                    checks++;
                    if ({rc_x3, rc_y3, rc_x4, rc_y4} !== {wx3[nn-1], wy3[nn-1], wx4[nn-1], wy4[nn-1]}) begin
                        errors++;
                        $display("FAIL %s wall_operands col %0d: got x3=%h expected x3=%h", name, col, rc_x3, wx3[nn-1]);
                    end
                end
                if (mode == 0) r = 1'b1;
                else if (mode == 1) r = 1'($urandom_range(0, 1));
                else begin
                    r = (stall >= 10);
                    stall++;
                end
                if (r) begin
                    if (mode == 0) begin
                        checks++;
                        if (cyc + 1 - last_hs != 3 + 3 * nn) begin
                            errors++;
                            $display("FAIL %s column_cycles col %0d: got %0d expected %0d", name, col, cyc + 1 - last_hs, 3 + 3 * nn);
                        end
                    end
                    if (col == 0) begin
                        first_hit = col_hit; first_dist = col_dist; first_uv = col_uv; first_wall = col_wall;
                    end
                    last_hs = cyc + 1;
                    col++;
                    stall = 0;
                end
            end else begin
                r = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
            end
            col_ready = r;
            pv = col_valid;
            pr = r;
            if (mode == 1 && col < NC) begin
                start = 1'($urandom_range(0, 1));
                player_x = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        col_ready = 1'b0;
        checks++;
        if (col != NC) begin
            errors++;
            $display("FAIL %s timeout: got %0d columns expected %0d", name, col, NC);
        end
        checks++;
        if ({frame_done, busy, col_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s frame_done_pulse: got done=%b busy=%b valid=%b expected 1 0 0", name, frame_done, busy, col_valid);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s frame_done_width: got %b expected 0", name, frame_done);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({ray_addr, wall_addr, rc_x1, rc_y1, rc_x2, rc_y2, rc_x3, rc_y3, rc_x4, rc_y4, col_valid,
             col_index, col_hit, col_dist, col_uv, col_wall, busy, frame_done} !== '0) begin
            errors++;
            $display("FAIL %s outputs_zero: got valid=%b busy=%b idx=%0d waddr=%0d rc_x1=%h dist=%h expected all 0",
                     name, col_valid, busy, col_index, wall_addr, rc_x1, col_dist);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_no_walls();
        fill_walls(1'b1);
        player_x = 16'($urandom);
        player_y = 16'($urandom);
        for (int i = 0; i < NC; i++) begin
            rdx[i] = 16'($urandom);
            rdy[i] = 16'($urandom);
        end
        run_frame(0, 0, "no_walls");
    endtask

    task automatic test_nearest();
        setup_directed();
        sh[0] = 1'b1; sd[0] = 16'h0800;
        sh[1] = 1'b1; sd[1] = 16'h0300;
        sh[2] = 1'b1; sd[2] = 16'h0500;
        run_frame(3, 0, "nearest");
        checks++;
        if ({first_hit, first_wall, first_dist, first_uv} !== {1'b1, 3'd1, 16'h0300, su[1]}) begin
            errors++;
            $display("FAIL nearest_const: got hit=%b wall=%0d dist=%h uv=%h expected 1 1 0300 %h",
                     first_hit, first_wall, first_dist, first_uv, su[1]);
        end
    endtask

    task automatic test_tie();
        setup_directed();
        sh[0] = 1'b1; sd[0] = 16'h0400;
        sh[1] = 1'b1; sd[1] = 16'h0400;
        run_frame(2, 0, "tie");
        checks++;
        if ({first_hit, first_wall, first_dist} !== {1'b1, 3'd0, 16'h0400}) begin
            errors++;
            $display("FAIL tie_const: got hit=%b wall=%0d dist=%h expected 1 0 0400", first_hit, first_wall, first_dist);
        end
    endtask

    task automatic test_stall();
        fill_walls(1'b1);
        player_x = 16'($urandom);
        player_y = 16'($urandom);
        run_frame(2, 2, "stall");
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        fill_walls(1'b1);
        @(negedge clk);
        fr_px = player_x;
        wall_count = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        col_ready = 1'b1;
        cyc = 0;
        while (!(col_index == 2'd2 && wall_addr == 3'd1 && busy) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 500) begin
            errors++;
            $display("FAIL mid_frame_wait: got %0d cycles expected under 500", cyc);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_frame_reset");
        col_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(3, 0, "after_reset");
    endtask

    task automatic test_far_clip();
        setup_directed();
        sh[0] = 1'b1; sd[0] = 16'h0400;
        run_frame(1, 0, "far_clip");
        checks++;
`ifdef RAY_SCAN_FAR_CLIP_EN
        if ({first_hit, first_dist} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL far_clip_const: got hit=%b dist=%h expected 0 0000", first_hit, first_dist);
        end
`else
        if ({first_hit, first_dist} !== {1'b1, 16'h0400}) begin
            errors++;
            $display("FAIL far_clip_const: got hit=%b dist=%h expected 1 0400", first_hit, first_dist);
        end
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            fill_walls(1'b1);
            player_x = 16'($urandom);
            player_y = 16'($urandom);
            for (int i = 0; i < NC; i++) begin
                rdx[i] = 16'($urandom);
                rdy[i] = 16'($urandom);
            end
            run_frame((it == 2) ? 12 : int'($urandom_range(1, 8)), it % 2, "random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        col_ready = 1'b0;
        player_x = 16'h0000;
        player_y = 16'h0000;
        wall_count = 4'd0;
        for (int i = 0; i < NC; i++) begin
            rdx[i] = 16'h0000;
            rdy[i] = 16'h0000;
        end
        fill_walls(1'b0);
        test_reset();
        test_no_walls();
        test_nearest();
        test_tie();
        test_stall();
        test_reset_mid_frame();
        test_far_clip();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
